// File: rtl/ft245_fifo_slv_if.sv
// Bus-side signal bundle of the FT600 16-bit 245-mode synchronous FIFO.
// The master modport is the FPGA FIFO-master view; the slave modport is the
// device-side responder view.
interface ft245_fifo_slv_if #(
  parameter int DW = 16,
  parameter int BW = 2
);

  // Master-driven strobes and data
  logic          wr_n;
  logic          rd_n;
  logic          oe_n;
  logic          siwu_n;
  logic [DW-1:0] m_data;
  logic [BW-1:0] m_be;

  // Slave-driven data and status
  logic [DW-1:0] s_data;
  logic [BW-1:0] s_be;
  logic          s_oe;
  logic          rxf_n;
  logic          txe_n;

  modport master (
    output wr_n, rd_n, oe_n, siwu_n, m_data, m_be,
    input  s_data, s_be, s_oe, rxf_n, txe_n
  );

  modport slave (
    input  wr_n, rd_n, oe_n, siwu_n, m_data, m_be,
    output s_data, s_be, s_oe, rxf_n, txe_n
  );

endinterface

// File: rtl/ft245_fifo_slv.sv
// FT600 device-side model of the 245-mode synchronous FIFO bus.
// TX buffer: host stream -> master reads (announced by rxf_n).
// RX buffer: master writes -> host stream, first-word-fall-through (txe_n).
// A small tracker FSM watches the master strobes for protocol violations.
module ft245_fifo_slv #(
  parameter int DW = 16,
  parameter int BW = 2,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  ft245_fifo_slv_if.slave bus,
  // Host feed into the TX buffer
  input  logic            tx_valid,
  input  logic [DW-1:0]   tx_data,
  input  logic [BW-1:0]   tx_be,
  output logic            tx_ready,
  // Host drain from the RX buffer
  output logic            rx_valid,
  output logic [DW-1:0]   rx_data,
  output logic [BW-1:0]   rx_be,
  input  logic            rx_ready,
  // Status
  output logic            siwu_pulse,
  output logic            ovf_err,
  output logic            unf_err,
  output logic            proto_err
);

  localparam int EW    = DW + BW;
  localparam int DEPTH = 1 << AW;

  typedef logic [AW:0]   ptr_t;
  typedef logic [EW-1:0] word_t;

  localparam ptr_t FULL_CNT    = ptr_t'(DEPTH);
  // Highest RX count that still leaves two free slots for the master.
  localparam ptr_t TXE_MAX_CNT = ptr_t'(DEPTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TURN,
    ST_RD,
    ST_WR
  } trk_state_t;

  // ---------------------------------------------------------------------
  // Master strobe decode
  // ---------------------------------------------------------------------
  logic rd_req;
  logic wr_req;

  assign rd_req = ~bus.oe_n & ~bus.rd_n;
  assign wr_req = ~bus.wr_n;

  // ---------------------------------------------------------------------
  // TX buffer (host -> master)
  // ---------------------------------------------------------------------
  word_t tx_mem [DEPTH];
  ptr_t  tx_wptr;
  ptr_t  tx_rptr;
  ptr_t  tx_count;
  ptr_t  tx_wptr_nxt;
  ptr_t  tx_rptr_nxt;
  ptr_t  tx_count_nxt;
  logic  tx_empty;
  logic  tx_push;
  logic  tx_pop;
  logic  tx_ready_q;
  logic  s_load;
  word_t s_head_nxt;
  word_t s_word_q;
  logic  s_oe_q;
  logic  rxf_n_q;

  assign tx_count     = tx_wptr - tx_rptr;
  assign tx_empty     = (tx_count == '0);
  // tx_ready_q is only high while the buffer has room, so no full check here.
  assign tx_push      = tx_valid & tx_ready_q;
  assign tx_pop       = rd_req & ~tx_empty;
  assign tx_wptr_nxt  = tx_wptr + ptr_t'(tx_push);
  assign tx_rptr_nxt  = tx_rptr + ptr_t'(tx_pop);
  assign tx_count_nxt = tx_wptr_nxt - tx_rptr_nxt;

  // The head after this edge is the word being pushed right now when the
  // read pointer lands on the current write slot; otherwise it is in memory.
  assign s_head_nxt = (tx_rptr_nxt == tx_wptr) ? {tx_be, tx_data}
                                               : tx_mem[tx_rptr_nxt[AW-1:0]];
  // Reload on a pop or a push into empty; hold when the buffer runs dry.
  assign s_load = (tx_pop | (tx_push & tx_empty)) & (tx_count_nxt != '0);

  // TX storage write port.
  // NOTE: storage arrays carry no reset; the pointers alone define what is
  // valid, and a reset-free array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= {tx_be, tx_data};
  end

  // TX pointers.
  // NOTE: all clocked state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      tx_wptr <= tx_wptr_nxt;
      tx_rptr <= tx_rptr_nxt;
    end
  end

  // Bus-facing TX registers: head word, output enable, rxf_n and tx_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_word_q   <= '0;
      s_oe_q     <= 1'b0;
      rxf_n_q    <= 1'b1;
      tx_ready_q <= 1'b0;
    end else begin
      if (s_load) s_word_q <= s_head_nxt;
      s_oe_q     <= ~bus.oe_n;
      rxf_n_q    <= (tx_count_nxt == '0);
      tx_ready_q <= (tx_count_nxt != FULL_CNT);
    end
  end

  assign {bus.s_be, bus.s_data} = s_word_q;
  assign bus.s_oe               = s_oe_q;
  assign bus.rxf_n              = rxf_n_q;
  assign tx_ready               = tx_ready_q;

  // ---------------------------------------------------------------------
  // RX buffer (master -> host)
  // ---------------------------------------------------------------------
  word_t rx_mem [DEPTH];
  ptr_t  rx_wptr;
  ptr_t  rx_rptr;
  ptr_t  rx_count;
  ptr_t  rx_wptr_nxt;
  ptr_t  rx_rptr_nxt;
  ptr_t  rx_count_nxt;
  logic  rx_full;
  logic  rx_push;
  logic  rx_pop;
  logic  txe_n_q;

  assign rx_count     = rx_wptr - rx_rptr;
  assign rx_full      = (rx_count == FULL_CNT);
  assign rx_push      = wr_req & ~rx_full;
  assign rx_valid     = (rx_count != '0);
  assign rx_pop       = rx_valid & rx_ready;
  assign rx_wptr_nxt  = rx_wptr + ptr_t'(rx_push);
  assign rx_rptr_nxt  = rx_rptr + ptr_t'(rx_pop);
  assign rx_count_nxt = rx_wptr_nxt - rx_rptr_nxt;

  assign {rx_be, rx_data} = rx_mem[rx_rptr[AW-1:0]];

  // RX storage write port.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= {bus.m_be, bus.m_data};
  end

  // RX pointers and txe_n; txe_n keeps one slot of slack for a write that
  // the master issues before it sees txe_n rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      txe_n_q <= 1'b1;
    end else begin
      rx_wptr <= rx_wptr_nxt;
      rx_rptr <= rx_rptr_nxt;
      txe_n_q <= (rx_count_nxt > TXE_MAX_CNT);
    end
  end

  assign bus.txe_n = txe_n_q;

  // ---------------------------------------------------------------------
  // Protocol tracker
  // ---------------------------------------------------------------------
  trk_state_t state_q;
  trk_state_t state_nxt;
  logic       proto_viol;

  // Tracker state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Tracker next state and violation decode.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state_q;
    proto_viol = 1'b0;

    if (wr_req & (~bus.oe_n | ~bus.rd_n))            proto_viol = 1'b1;
    if ((state_q == ST_IDLE) & ~bus.rd_n)            proto_viol = 1'b1;
    if (wr_req & ((state_q == ST_TURN) | (state_q == ST_RD)))
                                                     proto_viol = 1'b1;

    if (bus.oe_n & bus.rd_n & bus.wr_n) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (~bus.oe_n & bus.rd_n) state_nxt = ST_TURN;
          else if (wr_req)          state_nxt = ST_WR;
        end
        ST_TURN: if (~bus.rd_n)             state_nxt = ST_RD;
        ST_RD:   if (bus.rd_n & ~bus.oe_n)  state_nxt = ST_TURN;
        ST_WR:   state_nxt = ST_WR;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // SIWU edge detect and sticky error flags
  // ---------------------------------------------------------------------
  logic siwu_prev_q;

  // One-cycle pulse on a sampled falling edge of siwu_n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      siwu_prev_q <= 1'b1;
      siwu_pulse  <= 1'b0;
    end else begin
      siwu_prev_q <= bus.siwu_n;
      siwu_pulse  <= siwu_prev_q & ~bus.siwu_n;
    end
  end

  // Sticky errors: write into full RX, read from empty TX, bad strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (wr_req & rx_full)  ovf_err   <= 1'b1;
      if (rd_req & tx_empty) unf_err   <= 1'b1;
      if (proto_viol)        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ft245_fifo_slv.sv
// Directed bench for ft245_fifo_slv: reset, read burst, write fill on a
// 4-deep instance, streaming wrap in both directions, SIWU, protocol
// violation and reset mid-burst.
module tb_ft245_fifo_slv;

  localparam int N_STREAM = 3000;
  localparam int BUDGET   = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Full-depth instance
  ft245_fifo_slv_if #(.DW(16), .BW(2)) bus0 ();
  logic        tx_valid0, tx_ready0, rx_valid0, rx_ready0;
  logic [15:0] tx_data0, rx_data0;
  logic [1:0]  tx_be0, rx_be0;
  logic        siwu_pulse0, ovf_err0, unf_err0, proto_err0;

  ft245_fifo_slv #(.DW(16), .BW(2), .AW(10)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus0.slave),
    .tx_valid   (tx_valid0),
    .tx_data    (tx_data0),
    .tx_be      (tx_be0),
    .tx_ready   (tx_ready0),
    .rx_valid   (rx_valid0),
    .rx_data    (rx_data0),
    .rx_be      (rx_be0),
    .rx_ready   (rx_ready0),
    .siwu_pulse (siwu_pulse0),
    .ovf_err    (ovf_err0),
    .unf_err    (unf_err0),
    .proto_err  (proto_err0)
  );

  // 4-deep instance for the fill/overflow case
  ft245_fifo_slv_if #(.DW(16), .BW(2)) bus1 ();
  logic        tx_valid1, tx_ready1, rx_valid1, rx_ready1;
  logic [15:0] tx_data1, rx_data1;
  logic [1:0]  tx_be1, rx_be1;
  logic        siwu_pulse1, ovf_err1, unf_err1, proto_err1;

  ft245_fifo_slv #(.DW(16), .BW(2), .AW(2)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus1.slave),
    .tx_valid   (tx_valid1),
    .tx_data    (tx_data1),
    .tx_be      (tx_be1),
    .tx_ready   (tx_ready1),
    .rx_valid   (rx_valid1),
    .rx_data    (rx_data1),
    .rx_be      (rx_be1),
    .rx_ready   (rx_ready1),
    .siwu_pulse (siwu_pulse1),
    .ovf_err    (ovf_err1),
    .unf_err    (unf_err1),
    .proto_err  (proto_err1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream payload patterns, one word per index.
  function automatic logic [17:0] tx_word(input int i);
    logic [15:0] d;
    logic [1:0]  b;
    d = 16'(i * 40503 + 17);
    b = 2'(i ^ (i >> 3));
    return {b, d};
  endfunction

  function automatic logic [17:0] rx_word(input int i);
    logic [15:0] d;
    logic [1:0]  b;
    d = 16'(i * 21011) ^ 16'hC3A5;
    b = 2'((i >> 1) ^ 3);
    return {b, d};
  endfunction

  initial begin
    int pushed, popped, cyc, pulses;
    logic [17:0] w;

    bus0.wr_n = 1'b1; bus0.rd_n = 1'b1; bus0.oe_n = 1'b1; bus0.siwu_n = 1'b1;
    bus0.m_data = '0; bus0.m_be = '0;
    bus1.wr_n = 1'b1; bus1.rd_n = 1'b1; bus1.oe_n = 1'b1; bus1.siwu_n = 1'b1;
    bus1.m_data = '0; bus1.m_be = '0;
    tx_valid0 = 1'b0; tx_data0 = '0; tx_be0 = '0; rx_ready0 = 1'b0;
    tx_valid1 = 1'b0; tx_data1 = '0; tx_be1 = '0; rx_ready1 = 1'b0;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_rxf_n",     32'(bus0.rxf_n), 32'd1);
    check("rst_txe_n",     32'(bus0.txe_n), 32'd1);
    check("rst_s_oe",      32'(bus0.s_oe), 32'd0);
    check("rst_s_data",    32'({bus0.s_be, bus0.s_data}), 32'd0);
    check("rst_tx_ready",  32'(tx_ready0), 32'd0);
    check("rst_rx_valid",  32'(rx_valid0), 32'd0);
    check("rst_flags",     32'({siwu_pulse0, ovf_err0, unf_err0, proto_err0}), 32'd0);
    rst = 1'b0;
    step();
    check("rel_txe_n",     32'(bus0.txe_n), 32'd0);
    check("rel_tx_ready",  32'(tx_ready0), 32'd1);
    check("rel_rxf_n",     32'(bus0.rxf_n), 32'd1);
    check("rel_txe_n_s",   32'(bus1.txe_n), 32'd0);

    // ---------------- read burst ----------------
    for (int i = 1; i <= 4; i++) begin
      tx_valid0 = 1'b1; tx_data0 = 16'(i); tx_be0 = 2'b11;
      step();
      if (i == 1) begin
        check("rb_first_rxf_n",  32'(bus0.rxf_n), 32'd0);
        check("rb_first_s_data", 32'(bus0.s_data), 32'h0001);
      end
    end
    tx_valid0 = 1'b0;
    bus0.oe_n = 1'b0;
    step();
    check("rb_s_oe_on", 32'(bus0.s_oe), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      bus0.rd_n = 1'b0;
      check("rb_s_data", 32'({bus0.s_be, bus0.s_data}), 32'(18'h30000 | 18'(k)));
      check("rb_rxf_n_low", 32'(bus0.rxf_n), 32'd0);
      step();
    end
    check("rb_rxf_n_high", 32'(bus0.rxf_n), 32'd1);
    check("rb_s_data_hold", 32'(bus0.s_data), 32'h0004);
    bus0.rd_n = 1'b1; bus0.oe_n = 1'b1;
    step();
    check("rb_s_oe_off", 32'(bus0.s_oe), 32'd0);
    check("rb_errs", 32'({ovf_err0, unf_err0, proto_err0}), 32'd0);

    // ---------------- write fill (4-deep) ----------------
    for (int i = 0; i < 5; i++) begin
      bus1.wr_n = 1'b0; bus1.m_data = 16'hA000 + 16'(i); bus1.m_be = 2'b11;
      step();
      check("wf_txe_n", 32'(bus1.txe_n), (i >= 2) ? 32'd1 : 32'd0);
      check("wf_ovf",   32'(ovf_err1),   (i == 4) ? 32'd1 : 32'd0);
    end
    bus1.wr_n = 1'b1;
    step();
    rx_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("wf_rx_valid", 32'(rx_valid1), 32'd1);
      check("wf_rx_data",  32'(rx_data1), 32'hA000 + 32'(i));
      step();
    end
    rx_ready1 = 1'b0;
    check("wf_drained",   32'(rx_valid1), 32'd0);
    check("wf_txe_n_low", 32'(bus1.txe_n), 32'd0);

    // ---------------- TX stream with wrap ----------------
    pushed = 0; popped = 0; cyc = 0;
    bus0.oe_n = 1'b0;
    step();
    while (popped < N_STREAM && cyc < BUDGET) begin
      if (pushed < N_STREAM) begin
        w = tx_word(pushed);
        tx_valid0 = ($urandom_range(0, 3) != 0);
        {tx_be0, tx_data0} = w;
      end else begin
        tx_valid0 = 1'b0;
      end
      if (!bus0.rxf_n && $urandom_range(0, 3) != 0) begin
        bus0.rd_n = 1'b0;
        check("txs_word", 32'({bus0.s_be, bus0.s_data}), 32'(tx_word(popped)));
        popped++;
      end else begin
        bus0.rd_n = 1'b1;
      end
      if (tx_valid0 && tx_ready0) pushed++;
      step();
      cyc++;
    end
    check("txs_done", 32'(popped), 32'(N_STREAM));
    tx_valid0 = 1'b0; bus0.rd_n = 1'b1; bus0.oe_n = 1'b1;
    step();
    check("txs_rxf_n", 32'(bus0.rxf_n), 32'd1);
    check("txs_errs",  32'({ovf_err0, unf_err0, proto_err0}), 32'd0);

    // ---------------- RX stream with wrap ----------------
    pushed = 0; popped = 0; cyc = 0;
    while (popped < N_STREAM && cyc < BUDGET) begin
      if (pushed < N_STREAM && !bus0.txe_n && $urandom_range(0, 3) != 0) begin
        bus0.wr_n = 1'b0;
        {bus0.m_be, bus0.m_data} = rx_word(pushed);
        pushed++;
      end else begin
        bus0.wr_n = 1'b1;
      end
      rx_ready0 = ($urandom_range(0, 2) != 0);
      if (rx_ready0 && rx_valid0) begin
        check("rxs_word", 32'({rx_be0, rx_data0}), 32'(rx_word(popped)));
        popped++;
      end
      step();
      cyc++;
    end
    check("rxs_done", 32'(popped), 32'(N_STREAM));
    bus0.wr_n = 1'b1; rx_ready0 = 1'b0;
    step();
    check("rxs_empty", 32'(rx_valid0), 32'd0);
    check("rxs_errs",  32'({ovf_err0, unf_err0, proto_err0}), 32'd0);

    // ---------------- SIWU ----------------
    pulses = 0;
    bus0.siwu_n = 1'b0;
    step();
    check("siwu_first", 32'(siwu_pulse0), 32'd1);
    if (siwu_pulse0) pulses++;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) bus0.siwu_n = 1'b1;
      step();
      if (siwu_pulse0) pulses++;
    end
    check("siwu_count", 32'(pulses), 32'd1);

    // ---------------- protocol violation ----------------
    tx_valid0 = 1'b1; tx_data0 = 16'h55AA; tx_be0 = 2'b01;
    step();
    tx_valid0 = 1'b0;
    check("pv_pre_err", 32'(proto_err0), 32'd0);
    bus0.rd_n = 1'b0;
    step();
    bus0.rd_n = 1'b1;
    check("pv_proto_err", 32'(proto_err0), 32'd1);
    check("pv_no_pop",    32'(bus0.rxf_n), 32'd0);
    check("pv_s_data",    32'({bus0.s_be, bus0.s_data}), 32'h155AA);
    check("pv_unf",       32'(unf_err0), 32'd0);
    step();

    // ---------------- reset mid read burst ----------------
    for (int i = 0; i < 3; i++) begin
      tx_valid0 = 1'b1; tx_data0 = 16'h0010 + 16'(i); tx_be0 = 2'b11;
      step();
    end
    tx_valid0 = 1'b0;
    bus0.oe_n = 1'b0;
    step();
    bus0.rd_n = 1'b0;
    step();
    check("mr_pre_s_oe", 32'(bus0.s_oe), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_s_oe",     32'(bus0.s_oe), 32'd0);
    check("mr_rxf_n",    32'(bus0.rxf_n), 32'd1);
    check("mr_s_data",   32'({bus0.s_be, bus0.s_data}), 32'd0);
    check("mr_flags",    32'({tx_ready0, bus0.txe_n, proto_err0}), 32'b010);
    bus0.rd_n = 1'b1; bus0.oe_n = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("mr_txe_n",    32'(bus0.txe_n), 32'd0);
    check("mr_discard",  32'(bus0.rxf_n), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
